gold_code_sync: RTL
===================

# gold_code_sync

Chip-stream acquisition and lock tracker that sits directly downstream of the 15-stage Gold code generator. It regenerates the same Gold sequence locally from a 6-bit seed and compares it chip by chip with the received stream over fixed windows. It slips the local replica one chip at a time until agreement crosses a threshold, confirms the alignment, then monitors lock. Output is lock status plus diagnostic counts for the despreading stage.

## Interface
Parameters:
- WINDOW, 32: accepted chips per correlation window; power of two, 8..256.
- THRESH, 28: agreements needed to advance from SEARCH to VERIFY or from VERIFY to LOCKED.
- LOSS_THRESH, 20: in LOCKED, agreements below this drop lock.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse: load the local generators from seed and begin acquisition.
- seed  in  6  B-register seed, sampled only when start=1.
- chip_valid  in  1  chip qualifies in this cycle.
- chip  in  1  received chip.
- state  out  2  IDLE=0, SEARCH=1, VERIFY=2, LOCKED=3.
- locked  out  1  high exactly when state=LOCKED.
- window_done  out  1  one-cycle pulse at each window end.
- match_count  out  log2(WINDOW)+1  agreement count of the last completed window.
- slip_count  out  15  slips since the last start; saturates at 32767.

## Operation
- **Local generator:** two 15-bit shift-right registers, A and B.
  - A feedback into bit 14 is A[0]^A[1]. A load value is 0x4000.
  - B feedback into bit 14 is B[0]^B[1]^B[3]^B[12]. B load value is {0,1,7'b0,seed}.
  - Local chip = A[0]^B[0].
- **Accepted chip:** a cycle with chip_valid=1, start=0, rst=0, state≠IDLE.
  - Compare chip with the local chip. The agreement counter increments on equality.
  - Advance A and B by one.
  - Increment the window position.
- **Slip:** when a slip is pending, the next accepted chip is discarded instead of compared.
  - No compare, no generator advance, no window-position increment.
  - Clears the pending flag and increments slip_count (saturating).
  - Net effect: the local replica is delayed one chip relative to the stream.
- **Window end:** occurs on the edge accepting the WINDOW-th counted chip.
  - match_count ← final agreements, including that chip.
  - Agreement counter and window position clear.
  - window_done pulses.
  - Transition is evaluated against the final count.
- **Transitions at window end:**
  - SEARCH: count ≥ THRESH → VERIFY; otherwise stay and set slip pending.
  - VERIFY: count ≥ THRESH → LOCKED; otherwise → SEARCH and set slip pending.
  - LOCKED: count < LOSS_THRESH → SEARCH and set slip pending; otherwise stay.
- **start** (any state, including mid-window and LOCKED):
  - Reload A and B from seed.
  - Clear agreements, window position, match_count, slip_count, slip pending.
  - State → SEARCH. A chip_valid in the same cycle is ignored.
- **IDLE:** entered only via rst. Chips are ignored until start.
- chip_valid=0 cycles change nothing; gaps of any length are transparent.
- Acquisition only corrects a received stream that lags the local replica. A leading stream is absorbed by period wrap-around (32767 slips max).

## Timing
- **Reset values:** state=0, locked=0, window_done=0, match_count=0, slip_count=0, slip pending=0. A and B = 0.
- **Priority:** rst > start > accepted chip.
- All outputs are registered. State, locked, match_count and window_done update on the edge that accepts the last chip of a window and are visible the following cycle.
- window_done is high for exactly one cycle per window, never on a discarded (slip) chip.
- Minimum lock latency from start with an aligned stream: 2×WINDOW accepted chips.
- Each slip costs one extra accepted chip.

## Test plan
- **Reset:** assert rst with chip_valid toggling -> all outputs 0, state stays IDLE, no window_done without start.
- **Aligned:** seed=6'h2A, start, then drive the identical Gold sequence (same seed, generator loaded in the same cycle) on every cycle -> after 32 chips match_count=32, state=2. After 64 chips locked=1, state=3, slip_count=0.
- **Lagging by 3:** drive the same reference stream delayed 3 chips (first 3 chips = 0) -> windows 1–3 below 28, slip_count=3. Window 4 gives match_count=32, state=2. locked=1 after 163 accepted chips.
- **Errors while locked:**
  - Invert 4 chips in one window -> match_count=28, stays locked.
  - Invert 13 chips in a later window -> match_count=19, locked=0, state=1. The next accepted chip is discarded and slip_count increments by 1.
- **Valid gaps:** repeat the aligned case with random chip_valid=0 insertions (~40%) -> identical match_count, state sequence and lock point counted in accepted chips.
- **Restart:** pulse start mid-window while locked, with chip_valid=1 in the same cycle -> next cycle state=1, locked=0, match_count=0, slip_count=0. That chip is not counted. Re-lock after 64 more aligned chips.

Source files
------------

// File: rtl/gold_code_sync_if.sv
// rtl/gold_code_sync_if.sv - control/chip/status bundle for gold_code_sync
//
// Purpose: groups the acquisition controls, the received chip stream and the
//          lock/diagnostic outputs of gold_code_sync.
// Signals:
//   start        master->slave  1   load local generators from seed, begin search
//   seed         master->slave  6   B-register seed, used only with start
//   chip_valid   master->slave  1   chip qualifies this cycle
//   chip         master->slave  1   received chip
//   state        slave->master  2   IDLE=0 SEARCH=1 VERIFY=2 LOCKED=3
//   locked       slave->master  1   state==LOCKED
//   window_done  slave->master  1   one-cycle pulse per completed window
//   match_count  slave->master  CW  agreements in the last completed window
//   slip_count   slave->master  15  slips since last start, saturating
interface gold_code_sync_if #(
  parameter int WINDOW = 32
);
  localparam int CW = $clog2(WINDOW) + 1;

  logic          start;
  logic [5:0]    seed;
  logic          chip_valid;
  logic          chip;
  logic [1:0]    state;
  logic          locked;
  logic          window_done;
  logic [CW-1:0] match_count;
  logic [14:0]   slip_count;

  modport master (
    output start, seed, chip_valid, chip,
    input  state, locked, window_done, match_count, slip_count
  );

  modport slave (
    input  start, seed, chip_valid, chip,
    output state, locked, window_done, match_count, slip_count
  );
endinterface

// File: rtl/gold_code_sync.sv
// rtl/gold_code_sync.sv - Gold code chip-stream acquisition and lock tracker
//
// Purpose: regenerates the 15-stage Gold sequence locally, correlates it with
//          the received chip stream over WINDOW-chip windows, slips the local
//          replica one chip per failed window, and tracks SEARCH/VERIFY/LOCKED.
// Ports:
//   i_clk  in   clock, rising edge
//   i_rst  in   synchronous active-high reset
//   bus    slave modport of gold_code_sync_if (start/seed/chip_valid/chip in,
//          state/locked/window_done/match_count/slip_count out)
module gold_code_sync #(
  parameter int WINDOW      = 32,
  parameter int THRESH      = 28,
  parameter int LOSS_THRESH = 20
) (
  input  logic               i_clk,
  input  logic               i_rst,
  gold_code_sync_if.slave    bus
);

  localparam int CW = $clog2(WINDOW) + 1;
  localparam int PW = $clog2(WINDOW);

  localparam logic [CW-1:0] L_THRESH = CW'(THRESH);
  localparam logic [CW-1:0] L_LOSS   = CW'(LOSS_THRESH);
  localparam logic [PW-1:0] L_LAST   = PW'(WINDOW - 1);
  localparam logic [14:0]   L_A_LOAD = 15'h4000;
  localparam logic [14:0]   L_SAT    = 15'h7FFF;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_VERIFY = 2'd2,
    S_LOCKED = 2'd3
  } state_t;

  state_t        r_state;
  logic          r_locked;
  logic          r_wdone;
  logic [CW-1:0] r_match;
  logic [14:0]   r_slip;
  logic          r_pend;
  logic [CW-1:0] r_agree;
  logic [PW-1:0] r_pos;
  logic [14:0]   r_a;
  logic [14:0]   r_b;

  logic          w_local;
  logic          w_hit;
  logic          w_accept;
  logic [14:0]   w_a_next;
  logic [14:0]   w_b_next;
  logic [CW-1:0] w_agree_next;

  assign w_local      = r_a[0] ^ r_b[0];
  assign w_hit        = (bus.chip == w_local);
  assign w_accept     = bus.chip_valid && (r_state != S_IDLE);
  assign w_a_next     = {r_a[0] ^ r_a[1], r_a[14:1]};
  assign w_b_next     = {r_b[0] ^ r_b[1] ^ r_b[3] ^ r_b[12], r_b[14:1]};
  // Includes the current chip so the window-end decision sees the final count.
  assign w_agree_next = r_agree + {{(CW-1){1'b0}}, w_hit};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_locked <= 1'b0;
      r_wdone  <= 1'b0;
      r_match  <= '0;
      r_slip   <= '0;
      r_pend   <= 1'b0;
      r_agree  <= '0;
      r_pos    <= '0;
      r_a      <= '0;
      r_b      <= '0;
    end else if (bus.start) begin
      r_state  <= S_SEARCH;
      r_locked <= 1'b0;
      r_wdone  <= 1'b0;
      r_match  <= '0;
      r_slip   <= '0;
      r_pend   <= 1'b0;
      r_agree  <= '0;
      r_pos    <= '0;
      r_a      <= L_A_LOAD;
      r_b      <= {2'b01, 7'b0, bus.seed};
    end else begin
      r_wdone <= 1'b0;
      if (w_accept) begin
        if (r_pend) begin
          // Swallow this chip without advancing the replica: delays it by one.
          r_pend <= 1'b0;
          if (r_slip != L_SAT) r_slip <= r_slip + 15'd1;
        end else begin
          r_a <= w_a_next;
          r_b <= w_b_next;
          if (r_pos == L_LAST) begin
            r_match <= w_agree_next;
            r_agree <= '0;
            r_pos   <= '0;
            r_wdone <= 1'b1;
            case (r_state)
              S_SEARCH: begin
                if (w_agree_next >= L_THRESH) r_state <= S_VERIFY;
                else                          r_pend  <= 1'b1;
              end
              S_VERIFY: begin
                if (w_agree_next >= L_THRESH) begin
                  r_state  <= S_LOCKED;
                  r_locked <= 1'b1;
                end else begin
                  r_state <= S_SEARCH;
                  r_pend  <= 1'b1;
                end
              end
              S_LOCKED: begin
                if (w_agree_next < L_LOSS) begin
                  r_state  <= S_SEARCH;
                  r_locked <= 1'b0;
                  r_pend   <= 1'b1;
                end
              end
              default: ;
            endcase
          end else begin
            r_agree <= w_agree_next;
            r_pos   <= r_pos + 1'b1;
          end
        end
      end
    end
  end

  assign bus.state       = r_state;
  assign bus.locked      = r_locked;
  assign bus.window_done = r_wdone;
  assign bus.match_count = r_match;
  assign bus.slip_count  = r_slip;

endmodule
